vote_capture: RTL and testbench



---
 rtl/vote_capture.sv | 127 ++++++++++++
 tb/tb_vote_capture.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vote_capture.sv
// vote_capture: two-flop synchronised (VOTE_DEBOUNCE_EN: debounced) buttons feeding a timed session of sticky votes.
// btn->vote latency 3 edges (+DB_CYCLES when debounced); no backpressure, start ignored while a session is open.
module vote_capture #(
    parameter int WIN_CYCLES = 1000,
    parameter int DB_CYCLES  = 4,
    parameter int CW         = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [4:0]    btn,
    output logic          A,
    output logic          B,
    output logic          C,
    output logic          D,
    output logic          E,
    output logic          busy,
    output logic          done,
    output logic [2:0]    cnt,
    output logic [CW-1:0] remain
);

    typedef enum logic [1:0] {IDLE, VOTE, HOLD} state_t;

    state_t        state_q, state_d;
    logic [4:0]    s1_q, s2_q, f;
    logic [4:0]    votes_q, votes_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [CW-1:0] remain_q, remain_d;
    logic          done_q, done_d;

    if (WIN_CYCLES < 1 || DB_CYCLES < 1 || WIN_CYCLES > (2 ** CW) - 1) begin : g_param_check
        $error("vote_capture: WIN_CYCLES/DB_CYCLES/CW out of range");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= btn;
            s2_q <= s1_q;
        end
    end

`ifdef VOTE_DEBOUNCE_EN
    localparam int DBW = $clog2(DB_CYCLES) + 1;

    logic [DBW-1:0] db_cnt_q [5];
    logic [4:0]     f_q;

    // Counter tracks consecutive cycles the synchronised level disagrees with f.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_q <= '0;
            for (int i = 0; i < 5; i++) db_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (s2_q[i] == f_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DBW'(DB_CYCLES - 1)) begin
                    f_q[i]      <= s2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DBW'(1);
                end
            end
        end
    end

    assign f = f_q;
`else
    assign f = s2_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            votes_q  <= '0;
            cnt_q    <= '0;
            remain_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            votes_q  <= votes_d;
            cnt_q    <= cnt_d;
            remain_q <= remain_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        votes_d  = votes_q;
        cnt_d    = cnt_q;
        remain_d = remain_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE, HOLD: begin
                if (start) begin
                    state_d  = VOTE;
                    votes_d  = '0;
                    cnt_d    = '0;
                    remain_d = CW'(WIN_CYCLES);
                end
            end
            VOTE: begin
                // Votes seen on the closing edge still count.
                votes_d  = votes_q | f;
                cnt_d    = 3'($countones(votes_d));
                remain_d = remain_q - CW'(1);
                if (remain_q == CW'(1) || votes_d == 5'h1f) begin
                    state_d = HOLD;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign {A, B, C, D, E} = votes_q;
    assign busy            = (state_q == VOTE);
    assign done            = done_q;
    assign cnt             = cnt_q;
    assign remain          = remain_q;

endmodule

// File: tb/tb_vote_capture.sv
// Bench for vote_capture: history-based reference model, done-event scoreboard plus per-cycle output checks.
module tb_vote_capture;

    localparam int W  = 20;
    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  btn = 5'd0;
    logic        A, B, C, D, E, busy, done;
    logic [2:0]  cnt;
    logic [15:0] remain;

    vote_capture #(.WIN_CYCLES(W), .DB_CYCLES(DB), .CW(16)) dut (
        .clk(clk), .rst(rst), .start(start), .btn(btn),
        .A(A), .B(B), .C(C), .D(D), .E(E),
        .busy(busy), .done(done), .cnt(cnt), .remain(remain)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  v;
        logic [2:0]  c;
        logic [15:0] r;
    } res_t;

    res_t       exp_q[$];
    logic [4:0] hist[$];
    logic [4:0] m_f = 5'd0;
    logic [4:0] m_votes = 5'd0;
    logic       m_open = 1'b0;
    logic       m_done = 1'b0;
    int         m_remain = 0;
    logic       chk_en = 1'b0;
    int         n_vec = 0;
    int         n_err = 0;
    logic [4:0] rnd_b;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp_v);
        end
    endtask

    // Reference model: hist[j] holds the btn sample taken j+1 edges before the current one.
    always @(posedge clk) begin
        logic [4:0] f_now;
        int ones;
        if (rst) begin
            hist.delete();
            for (int i = 0; i < DB + 2; i++) hist.push_front(5'd0);
            m_f = 5'd0; m_votes = 5'd0; m_open = 1'b0; m_done = 1'b0; m_remain = 0;
            chk_en = 1'b1;
        end else begin
`ifdef VOTE_DEBOUNCE_EN
            for (int b = 0; b < 5; b++) begin
                ones = 0;
                for (int j = 2; j <= DB + 1; j++) ones += int'(hist[j][b]);
                if (ones == DB) m_f[b] = 1'b1;
                else if (ones == 0) m_f[b] = 1'b0;
            end
            f_now = m_f;
`else
            f_now = hist[1];
`endif
            hist.push_front(btn);
            void'(hist.pop_back());
            m_done = 1'b0;
            if (!m_open) begin
                if (start) begin
                    m_open = 1'b1; m_votes = 5'd0; m_remain = W;
                end
            end else begin
                m_votes  = m_votes | f_now;
                m_remain = m_remain - 1;
                if (m_remain == 0 || m_votes == 5'h1f) begin
                    m_open = 1'b0;
                    m_done = 1'b1;
                    exp_q.push_back('{m_votes, 3'($countones(m_votes)), 16'(m_remain)});
                end
            end
        end
    end

    // Monitor: per-cycle state checks; session result popped whenever done is presented.
    always @(negedge clk) begin
        res_t r;
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_open));
            chk("votes", 32'({A, B, C, D, E}), 32'(m_votes));
            chk("cnt", 32'(cnt), 32'($countones(m_votes)));
            chk("remain", 32'(remain), 32'(m_remain));
            chk("done", 32'(done), 32'(m_done));
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_done at %0t: got done=1 want no pending session result", $time);
                end else begin
                    r = exp_q.pop_front();
                    chk("done_votes", 32'({A, B, C, D, E}), 32'(r.v));
                    chk("done_cnt", 32'(cnt), 32'(r.c));
                    chk("done_remain", 32'(remain), 32'(r.r));
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic s, input logic [4:0] b);
        @(negedge clk);
        rst = r; start = s; btn = b;
    endtask

    initial begin
        // Reset then idle with all buttons pressed.
        cyc(1, 0, 5'h00); cyc(1, 0, 5'h00);
        repeat (10) cyc(0, 0, 5'h1f);
        repeat (8) cyc(0, 0, 5'h00);

        // Full window, A/B/C pressed from t+3, then buttons change in HOLD.
        cyc(0, 1, 5'h00);
        cyc(0, 0, 5'h00); cyc(0, 0, 5'h00);
        repeat (25) cyc(0, 0, 5'b11100);
        repeat (5) cyc(0, 0, 5'b00011);
        repeat (8) cyc(0, 0, 5'h00);

        // Early close with all buttons.
        cyc(0, 1, 5'h00);
        repeat (12) cyc(0, 0, 5'h1f);
        repeat (8) cyc(0, 0, 5'h00);

        // Stickiness: A alone for 10 cycles.
        cyc(0, 1, 5'h00);
        repeat (10) cyc(0, 0, 5'b10000);
        repeat (15) cyc(0, 0, 5'h00);

        // Short glitch on E, then a clean press.
        cyc(0, 1, 5'h00);
        repeat (3) cyc(0, 0, 5'b00001);
        repeat (4) cyc(0, 0, 5'h00);
        repeat (8) cyc(0, 0, 5'b00001);
        repeat (10) cyc(0, 0, 5'h00);

        // Reset mid-session.
        cyc(0, 1, 5'h00);
        repeat (5) cyc(0, 0, 5'b01000);
        cyc(1, 0, 5'h00);
        repeat (3) cyc(0, 0, 5'h00);

        // Session with start ignored mid-window, start on the expiry edge, restart right after done.
        cyc(0, 1, 5'h00);
        repeat (5) cyc(0, 0, 5'b00100);
        cyc(0, 1, 5'b00100);
        repeat (13) cyc(0, 0, 5'h00);
        cyc(0, 1, 5'h00);
        cyc(0, 1, 5'h00);
        repeat (6) cyc(0, 0, 5'b01010);
        repeat (20) cyc(0, 0, 5'h00);

        // Start from HOLD clears the previous votes.
        cyc(0, 1, 5'h00);
        repeat (22) cyc(0, 0, 5'h00);

        // Random traffic.
        rnd_b = 5'd0;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 5; i++)
                if ($urandom_range(7) == 0) rnd_b[i] = ~rnd_b[i];
            cyc(($urandom_range(249) == 0), ($urandom_range(11) == 0), rnd_b);
        end
        repeat (3) cyc(0, 0, 5'h00);
        @(negedge clk);

        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_done: got %0d undelivered session results want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
